// File: rtl/linked_list_fifo_drain_pkg.sv
// -----------------------------------------------------------------------------
// linked_list_fifo_drain_pkg
// Shared definitions for the linked-list FIFO drain stage:
//   - drain_state_t : INIT / RUN state encoding used by the top-level FSM
//   - log2()        : number of bits needed to represent a value, used to size
//                     queue indices, FIFO addresses and counters
//   - SKID_ENTRIES  : depth of the output skid buffer
// -----------------------------------------------------------------------------
package linked_list_fifo_drain_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } drain_state_t;

    localparam int SKID_ENTRIES = 2;

    // Bits needed to hold 'value' (log2(7)=3, log2(31)=5); never less than 1.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        for (int i = 0; i < 31; i++) begin
            if (value >= (1 << i)) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/linked_list_fifo_drain_rr_arbiter.sv
// -----------------------------------------------------------------------------
// linked_list_fifo_drain_rr_arbiter
// Purely combinational round-robin arbiter. Picks the first asserted request
// at or after rr_ptr, wrapping modulo FIFOS.
// Ports:
//   req         in  FIFOS       one request bit per queue
//   rr_ptr      in  LOG2_FIFOS  queue with highest priority this cycle
//   grant       out FIFOS       one-hot grant (all zero when nothing requests)
//   grant_idx   out LOG2_FIFOS  index of the granted queue
//   grant_valid out 1           some request was granted
// -----------------------------------------------------------------------------
module linked_list_fifo_drain_rr_arbiter
    import linked_list_fifo_drain_pkg::*;
#(
    parameter int FIFOS      = 8,
    parameter int LOG2_FIFOS = log2(FIFOS - 1)
) (
    input  logic [FIFOS-1:0]      req,
    input  logic [LOG2_FIFOS-1:0] rr_ptr,
    output logic [FIFOS-1:0]      grant,
    output logic [LOG2_FIFOS-1:0] grant_idx,
    output logic                  grant_valid
);

    logic [LOG2_FIFOS-1:0] idx;

    // Walk the queues starting at rr_ptr; the first requester wins and later
    // ones are masked by grant_valid.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int off = 0; off < FIFOS; off++) begin
            idx = LOG2_FIFOS'((int'(rr_ptr) + off) % FIFOS);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/linked_list_fifo_drain.sv
// -----------------------------------------------------------------------------
// linked_list_fifo_drain
// Downstream drain stage for the multi-queue linked-list FIFO. It snoops the
// FIFO push side to track per-queue occupancy, pops non-empty queues in
// round-robin order and forwards the FIFO's registered q, tagged with its
// queue number, through a 2-entry skid buffer on a valid/ready interface.
// Ports:
//   clk              in  1                    clock
//   rst_n            in  1                    asynchronous active-low reset
//   snoop_push       in  1                    copy of FIFO push
//   snoop_push_fifo  in  LOG2_FIFOS           copy of FIFO push_fifo
//   pop              out 1                    FIFO pop (combinational)
//   pop_fifo         out LOG2_FIFOS           FIFO pop_fifo (combinational)
//   fifo_q           in  WIDTH                FIFO q, valid the cycle after pop
//   out_valid        out 1                    output word valid
//   out_ready        in  1                    consumer accepts the word
//   out_data         out WIDTH                output word
//   out_fifo         out LOG2_FIFOS           source queue of out_data
//   occupancy        out (LOG2_DEPTH+1)*FIFOS per-queue counts, queue i at
//                                             [i*(LOG2_DEPTH+1) +: LOG2_DEPTH+1]
//   busy             out 1                    INIT, or any count/in-flight/
//                                             buffered word nonzero
// -----------------------------------------------------------------------------
module linked_list_fifo_drain
    import linked_list_fifo_drain_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 32,
    parameter int FIFOS       = 8,
    parameter int LOG2_FIFOS  = log2(FIFOS - 1),
    parameter int LOG2_DEPTH  = log2(DEPTH - 1),
    parameter int INIT_CYCLES = DEPTH + 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            snoop_push,
    input  logic [LOG2_FIFOS-1:0]           snoop_push_fifo,
    output logic                            pop,
    output logic [LOG2_FIFOS-1:0]           pop_fifo,
    input  logic [WIDTH-1:0]                fifo_q,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [LOG2_FIFOS-1:0]           out_fifo,
    output logic [(LOG2_DEPTH+1)*FIFOS-1:0] occupancy,
    output logic                            busy
);

    localparam int CNT_W  = LOG2_DEPTH + 1;
    localparam int INIT_W = log2(INIT_CYCLES - 1);

    drain_state_t          state;
    drain_state_t          state_next;
    logic [INIT_W-1:0]     init_cnt;
    logic                  is_run;

    logic [CNT_W-1:0]      occ [FIFOS];
    logic [FIFOS-1:0]      push_hit;
    logic [FIFOS-1:0]      pop_hit;
    logic [FIFOS-1:0]      eligible;
    logic                  any_occ;

    logic [LOG2_FIFOS-1:0] rr_ptr;
    logic [FIFOS-1:0]      grant;
    logic [LOG2_FIFOS-1:0] grant_idx;
    logic                  grant_valid;

    logic                  inflight;
    logic [LOG2_FIFOS-1:0] inflight_tag;

    logic [WIDTH-1:0]      buf_data [SKID_ENTRIES];
    logic [LOG2_FIFOS-1:0] buf_tag  [SKID_ENTRIES];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            buf_count;
    logic                  out_xfer;
    logic [2:0]            outstanding;
    logic                  credit_ok;

    assign is_run = (state == ST_RUN);

    // State register. INIT is re-entered only through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Init counter: gives the FIFO time to build its free list before the
    // first pop. It parks at its final value once RUN is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if (state == ST_INIT && init_cnt != INIT_W'(INIT_CYCLES - 1)) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    // Next-state and pop outputs. Pop is combinational so the FIFO sees it in
    // the same cycle; it needs a granted queue and a free slot downstream.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        pop_fifo   = '0;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (grant_valid && credit_ok) begin
                    pop      = 1'b1;
                    pop_fifo = grant_idx;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    // Per-queue push/pop strobes and eligibility. Eligibility looks only at
    // the registered count, so a push landing this cycle cannot trigger a pop
    // of a list the FIFO has not linked yet.
    always_comb begin
        push_hit = '0;
        pop_hit  = '0;
        eligible = '0;
        any_occ  = 1'b0;
        for (int i = 0; i < FIFOS; i++) begin
            push_hit[i] = is_run && snoop_push && (snoop_push_fifo == LOG2_FIFOS'(i));
            pop_hit[i]  = pop && (pop_fifo == LOG2_FIFOS'(i));
            eligible[i] = is_run && (occ[i] != '0);
            any_occ     = any_occ || (occ[i] != '0);
        end
    end

    // Occupancy counters. A push and a pop on the same queue cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFOS; i++) begin
                occ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFOS; i++) begin
                if (push_hit[i] && !pop_hit[i]) begin
                    occ[i] <= occ[i] + 1'b1;
                end else if (pop_hit[i] && !push_hit[i]) begin
                    occ[i] <= occ[i] - 1'b1;
                end
            end
        end
    end

    // Counts must stay within 0..DEPTH; crossing either bound means the
    // snooped push stream and this block have fallen out of step.
    for (genvar g = 0; g < FIFOS; g++) begin : g_occ_bounds
        assert property (@(posedge clk) disable iff (!rst_n)
            (push_hit[g] && !pop_hit[g]) |-> (occ[g] != CNT_W'(DEPTH)));
        assert property (@(posedge clk) disable iff (!rst_n)
            (pop_hit[g] && !push_hit[g]) |-> (occ[g] != '0));
    end

    // Pack the count array onto the flat occupancy port.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < FIFOS; i++) begin
            occupancy[i*CNT_W +: CNT_W] = occ[i];
        end
    end

    linked_list_fifo_drain_rr_arbiter #(
        .FIFOS      (FIFOS),
        .LOG2_FIFOS (LOG2_FIFOS)
    ) u_rr_arbiter (
        .req         (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Round-robin pointer moves just past the queue that was actually popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (pop) begin
            if (grant_idx == LOG2_FIFOS'(FIFOS - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + 1'b1;
            end
        end
    end

    // Credit: words already owed to the buffer (stored plus in flight), less
    // the one leaving this cycle, must leave room for one more.
    assign out_xfer    = out_valid && out_ready;
    assign outstanding = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, out_xfer};
    assign credit_ok   = (outstanding < 3'd2);

    // In-flight marker: the FIFO's q is valid the cycle after a pop, so the
    // tag is delayed by one cycle to line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= 1'b0;
            inflight_tag <= '0;
        end else begin
            inflight     <= pop;
            inflight_tag <= pop_fifo;
        end
    end

    // Two-entry skid buffer kept as a tiny circular FIFO. Write and read in
    // the same cycle both take effect and leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_ENTRIES; i++) begin
                buf_data[i] <= '0;
                buf_tag[i]  <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            buf_count <= 2'd0;
        end else begin
            if (inflight) begin
                buf_data[wr_ptr] <= fifo_q;
                buf_tag[wr_ptr]  <= inflight_tag;
                wr_ptr           <= ~wr_ptr;
            end
            if (out_xfer) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({inflight, out_xfer})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    assign out_valid = (buf_count != 2'd0);
    assign out_data  = buf_data[rd_ptr];
    assign out_fifo  = buf_tag[rd_ptr];
    assign busy      = (state == ST_INIT) || any_occ || inflight || (buf_count != 2'd0);

endmodule

// File: tb/tb_linked_list_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_linked_list_fifo_drain
// Directed bench for linked_list_fifo_drain. The bench plays the role of the
// linked-list FIFO (a per-queue store returning q one cycle after pop) and
// keeps a queue-level model of what the drain stage must do every cycle.
// -----------------------------------------------------------------------------
module tb_linked_list_fifo_drain;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 32;
    localparam int FIFOS       = 8;
    localparam int LOG2_FIFOS  = 3;
    localparam int LOG2_DEPTH  = 5;
    localparam int CNT_W       = LOG2_DEPTH + 1;
    localparam int INIT_CYCLES = DEPTH + 4;

    logic                    clk;
    logic                    rst_n;
    logic                    snoop_push;
    logic [LOG2_FIFOS-1:0]   snoop_push_fifo;
    logic                    pop;
    logic [LOG2_FIFOS-1:0]   pop_fifo;
    logic [WIDTH-1:0]        fifo_q;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [LOG2_FIFOS-1:0]   out_fifo;
    logic [CNT_W*FIFOS-1:0]  occupancy;
    logic                    busy;

    logic [WIDTH-1:0]        push_data;
    logic [WIDTH-1:0]        pending_q;

    int n_checks;
    int n_pass;

    linked_list_fifo_drain #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .FIFOS       (FIFOS),
        .LOG2_FIFOS  (LOG2_FIFOS),
        .LOG2_DEPTH  (LOG2_DEPTH),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .snoop_push      (snoop_push),
        .snoop_push_fifo (snoop_push_fifo),
        .pop             (pop),
        .pop_fifo        (pop_fifo),
        .fifo_q          (fifo_q),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_fifo        (out_fifo),
        .occupancy       (occupancy),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO stand-in: q for a pop in cycle t appears just after the edge that
    // ends t and holds through t+1.
    initial begin
        fifo_q = '0;
        forever begin
            @(posedge clk);
            #1;
            fifo_q = pending_q;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    function automatic int occOf(input int q);
        return int'(occupancy[q*CNT_W +: CNT_W]);
    endfunction

    // One cycle of stimulus: inputs change just after the rising edge, and the
    // task returns at the falling edge so callers can look at settled outputs.
    task automatic applyStimulus(input bit push, input int q, input logic [7:0] d, input bit ready);
        @(posedge clk);
        #1;
        snoop_push      = push;
        snoop_push_fifo = LOG2_FIFOS'(q);
        push_data       = d;
        out_ready       = ready;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Queue-level model: occupancy per queue, the data stored in each
    // queue, a round-robin pointer, and the list of words owed to the
    // consumer together with the cycle they were popped.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] d;
        int         tag;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [7:0] stub_mem [FIFOS][64];
    int         stub_rd [FIFOS];
    int         stub_wr [FIFOS];
    int         m_occ [FIFOS];
    int         m_rr;
    int         m_cnt;
    bit         m_run;
    int         cyc;
    int         g;
    int         qq;
    bit         ev;
    bit         ex;
    bit         ep;
    bit         eb;

    // Compare process: each falling edge, derive this cycle's required
    // outputs from the model, check them, then advance the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_pop", int'(pop), 0);
            checkOutput("rst_pop_fifo", int'(pop_fifo), 0);
            checkOutput("rst_out_valid", int'(out_valid), 0);
            checkOutput("rst_out_data", int'(out_data), 0);
            checkOutput("rst_out_fifo", int'(out_fifo), 0);
            checkOutput("rst_busy", int'(busy), 1);
            checkOutput("rst_occupancy", (occupancy == '0) ? 1 : 0, 1);
            m_run = 1'b0;
            m_cnt = 0;
            m_rr  = 0;
            cyc   = 0;
            exp_q.delete();
            for (int q = 0; q < FIFOS; q++) begin
                m_occ[q]   = 0;
                stub_rd[q] = 0;
                stub_wr[q] = 0;
            end
        end else begin
            ev = 1'b0;
            if (exp_q.size() != 0) begin
                ev = (exp_q[0].cyc + 2 <= cyc);
            end
            ex = ev && out_ready;
            g  = -1;
            if (m_run) begin
                for (int k = 0; k < FIFOS; k++) begin
                    qq = (m_rr + k) % FIFOS;
                    if (g < 0 && m_occ[qq] != 0) g = qq;
                end
            end
            ep = (g >= 0) && ((exp_q.size() - int'(ex)) < 2);
            eb = !m_run || (exp_q.size() != 0);
            for (int q = 0; q < FIFOS; q++) begin
                if (m_occ[q] != 0) eb = 1'b1;
            end

            checkOutput("pop", int'(pop), int'(ep));
            if (ep) checkOutput("pop_fifo", int'(pop_fifo), g);
            checkOutput("out_valid", int'(out_valid), int'(ev));
            if (ev) begin
                checkOutput("out_data", int'(out_data), int'(exp_q[0].d));
                checkOutput("out_fifo", int'(out_fifo), exp_q[0].tag);
            end
            checkOutput("busy", int'(busy), int'(eb));
            for (int q = 0; q < FIFOS; q++) begin
                checkOutput("occupancy", occOf(q), m_occ[q]);
            end

            if (ex) void'(exp_q.pop_front());
            if (ep) begin
                e.d   = stub_mem[g][stub_rd[g] % 64];
                e.tag = g;
                e.cyc = cyc;
                exp_q.push_back(e);
                stub_rd[g]++;
                pending_q = e.d;
                m_occ[g]--;
                m_rr = (g + 1) % FIFOS;
            end
            if (m_run && snoop_push) begin
                stub_mem[snoop_push_fifo][stub_wr[snoop_push_fifo] % 64] = push_data;
                stub_wr[snoop_push_fifo]++;
                m_occ[snoop_push_fifo]++;
            end
            if (!m_run) begin
                m_cnt++;
                if (m_cnt == INIT_CYCLES) m_run = 1'b1;
            end
            cyc++;
        end
    end

    int         pop_seq[$];
    int         pop_cyc[$];
    int         exp_seq[6];
    int         pop_count;
    logic [7:0] got[$];

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        snoop_push      = 1'b0;
        snoop_push_fifo = '0;
        push_data       = '0;
        pending_q       = '0;
        out_ready       = 1'b1;
        exp_seq         = '{5, 0, 1, 5, 0, 1};

        // Reset release; pushes to q2 during INIT must be ignored.
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("init_pop", int'(pop), 0);
        checkOutput("init_busy", int'(busy), 1);
        for (int i = 1; i < INIT_CYCLES; i++) begin
            applyStimulus((i >= 2 && i <= 4), 2, 8'(8'h20 + i), 1'b1);
            checkOutput("init_pop", int'(pop), 0);
            checkOutput("init_occ2", occOf(2), 0);
            checkOutput("init_busy", int'(busy), 1);
        end
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("run_busy", int'(busy), 0);
        checkOutput("run_occ2", occOf(2), 0);

        // Single word through q3.
        applyStimulus(1'b1, 3, 8'hA1, 1'b1);
        checkOutput("q3_same_cycle_pop", int'(pop), 0);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("q3_pop", int'(pop), 1);
        checkOutput("q3_pop_fifo", int'(pop_fifo), 3);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("q3_not_yet_valid", int'(out_valid), 0);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("q3_out_valid", int'(out_valid), 1);
        checkOutput("q3_out_data", int'(out_data), 'hA1);
        checkOutput("q3_out_fifo", int'(out_fifo), 3);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);

        // Round robin from rr_ptr=4: fill the skid buffer from q3 first so no
        // pops can happen while q0/q1/q5 are loaded.
        applyStimulus(1'b1, 3, 8'hB0, 1'b0);
        applyStimulus(1'b1, 3, 8'hB1, 1'b0);
        applyStimulus(1'b1, 0, 8'h10, 1'b0);
        applyStimulus(1'b1, 1, 8'h11, 1'b0);
        applyStimulus(1'b1, 5, 8'h12, 1'b0);
        applyStimulus(1'b1, 0, 8'h13, 1'b0);
        applyStimulus(1'b1, 1, 8'h14, 1'b0);
        applyStimulus(1'b1, 5, 8'h15, 1'b0);
        applyStimulus(1'b0, 0, 8'h00, 1'b0);
        checkOutput("rr_blocked_pop", int'(pop), 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 0, 8'h00, 1'b1);
            if (pop) begin
                pop_seq.push_back(int'(pop_fifo));
                pop_cyc.push_back(i);
            end
        end
        checkOutput("rr_pop_count", pop_seq.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("rr_pop_order", (i < pop_seq.size()) ? pop_seq[i] : -1, exp_seq[i]);
        end
        if (pop_seq.size() == 6) begin
            checkOutput("rr_no_gaps", pop_cyc[5] - pop_cyc[0], 5);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1);

        // Stalled consumer with q6 holding 5 words.
        pop_count = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 6, 8'(8'h60 + i), 1'b0);
            if (pop) pop_count++;
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 0, 8'h00, 1'b0);
            if (pop) pop_count++;
            checkOutput("stall_valid", int'(out_valid), 1);
            checkOutput("stall_data", int'(out_data), 'h60);
        end
        checkOutput("stall_pop_count", pop_count, 2);
        checkOutput("stall_occ6", occOf(6), 3);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 0, 8'h00, 1'b1);
            if (out_valid) got.push_back(out_data);
        end
        checkOutput("drain_word_count", got.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput("drain_word", (i < got.size()) ? int'(got[i]) : -1, 'h60 + i);
        end
        checkOutput("drain_occ6", occOf(6), 0);

        // Same-cycle push and pop on q4, then a push to empty q7.
        applyStimulus(1'b1, 4, 8'h40, 1'b1);
        applyStimulus(1'b1, 4, 8'h41, 1'b1);
        checkOutput("q4_pop", int'(pop), 1);
        checkOutput("q4_pop_fifo", int'(pop_fifo), 4);
        checkOutput("q4_occ_before", occOf(4), 1);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("q4_occ_held", occOf(4), 1);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("q4_occ_empty", occOf(4), 0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1);
        applyStimulus(1'b1, 7, 8'h77, 1'b1);
        checkOutput("q7_push_no_pop", int'(pop), 0);
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("q7_pop", int'(pop), 1);
        checkOutput("q7_pop_fifo", int'(pop_fifo), 7);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1);

        // Reset with two words parked in the skid buffer.
        applyStimulus(1'b1, 2, 8'h70, 1'b0);
        applyStimulus(1'b1, 2, 8'h71, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 8'h00, 1'b0);
        checkOutput("pre_reset_valid", int'(out_valid), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_valid", int'(out_valid), 0);
        checkOutput("async_reset_busy", int'(busy), 1);
        checkOutput("async_reset_pop", int'(pop), 0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 1; i < INIT_CYCLES; i++) begin
            applyStimulus(1'b0, 0, 8'h00, 1'b1);
            checkOutput("reinit_busy", int'(busy), 1);
        end
        applyStimulus(1'b0, 0, 8'h00, 1'b1);
        checkOutput("reinit_run_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
